// File: rtl/accum_bcd_convert.sv
// Converts the calculator accumulator to packed BCD, using a sequential double-dabble engine.
// Define ACCUM_BCD_SIGNED_EN to treat accum as two's complement and report sign plus magnitude.
module accum_bcd_convert #(
  parameter int BITS   = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BITS-1:0]     accum,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                bcd_valid,
  output logic                busy,
  output logic                sign
);

  localparam int CW = $clog2(BITS + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [BITS-1:0] last_conv;
  logic [BITS-1:0] shift_reg;
  logic [BITS-1:0] magnitude;
  logic [BW-1:0]   work;
  logic [BW-1:0]   work_adj;
  logic [BW-1:0]   work_shifted;
  logic [CW-1:0]   count;
  logic            start;
  logic            last_shift;

`ifdef ACCUM_BCD_SIGNED_EN
  logic sign_cap;

  // Negating the most-negative value wraps to itself, which is the correct unsigned magnitude.
  assign magnitude = accum[BITS-1] ? (~accum + 1'b1) : accum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_cap <= 1'b0;
      sign     <= 1'b0;
    end else begin
      if (start)
        sign_cap <= accum[BITS-1];
      if (last_shift)
        sign <= sign_cap;
    end
  end
`else
  assign magnitude = accum;
  assign sign      = 1'b0;
`endif

  always_comb begin
    work_adj = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5)
        work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
  end

  assign work_shifted = {work_adj[BW-2:0], shift_reg[BITS-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    last_shift = 1'b0;
    busy       = 1'b0;
    bcd_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accum != last_conv) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == CW'(1)) begin
          last_shift = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        bcd_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final shift result is latched straight into bcd_out so that partial results never show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_conv <= '0;
      shift_reg <= '0;
      work      <= '0;
      count     <= '0;
      bcd_out   <= '0;
    end else if (start) begin
      last_conv <= accum;
      shift_reg <= magnitude;
      work      <= '0;
      count     <= CW'(BITS);
    end else if (busy) begin
      work      <= work_shifted;
      shift_reg <= {shift_reg[BITS-2:0], 1'b0};
      count     <= count - 1'b1;
      if (last_shift)
        bcd_out <= work_shifted;
    end
  end

endmodule

// File: tb/tb_accum_bcd_convert.sv
// Self-checking bench for accum_bcd_convert against a decimal-arithmetic reference model.
module tb_accum_bcd_convert;

  localparam int BITS   = 32;
  localparam int DIGITS = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [BITS-1:0]     accum;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic                busy;
  logic                sign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  accum_bcd_convert #(.BITS(BITS), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .accum     (accum),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .sign      (sign)
  );

  // Reference: decimal digits of the (possibly signed) value via plain division.
  function automatic logic [4*DIGITS-1:0] model_bcd(input logic [BITS-1:0] v);
    longint unsigned     m;
    logic [4*DIGITS-1:0] r;
`ifdef ACCUM_BCD_SIGNED_EN
    m = v[BITS-1] ? (64'h1_0000_0000 - 64'(v)) : 64'(v);
`else
    m = 64'(v);
`endif
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic model_sign(input logic [BITS-1:0] v);
`ifdef ACCUM_BCD_SIGNED_EN
    return v[BITS-1];
`else
    return 1'b0 & v[0];
`endif
  endfunction

  task automatic wait_valid(input int limit, output int cycles, output bit got);
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (bcd_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    int pulses    = 0;
    int busy_seen = 0;
    reset = 1'b1;
    accum = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bcd_valid) pulses++;
      if (busy) busy_seen++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got %0d pulses, required 0", pulses);
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("[TB] FAIL reset_busy: busy seen %0d cycles, required 0", busy_seen);
    end
    checks++;
    if (bcd_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bcd_out: got %h, required 0", bcd_out);
    end
    checks++;
    if (sign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_sign: got %b, required 0", sign);
    end
  endtask

  task automatic test_latency();
    logic [4*DIGITS-1:0] exp_bcd;
    exp_bcd = model_bcd(32'd123);
    @(negedge clk);
    accum = 32'd123;
    for (int k = 1; k <= BITS; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || bcd_valid !== 1'b0 || bcd_out !== '0) begin
        errors++;
        $display("[TB] FAIL latency_busy cycle %0d: busy=%b valid=%b out=%h, required busy=1 valid=0 out=0",
                 k, busy, bcd_valid, bcd_out);
      end
    end
    @(negedge clk);
    checks++;
    if (bcd_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_done: valid=%b busy=%b, required valid=1 busy=0", bcd_valid, busy);
    end
    checks++;
    if (bcd_out !== exp_bcd) begin
      errors++;
      $display("[TB] FAIL latency_value: got %h, required %h", bcd_out, exp_bcd);
    end
    @(negedge clk);
    checks++;
    if (bcd_valid !== 1'b0 || bcd_out !== exp_bcd) begin
      errors++;
      $display("[TB] FAIL latency_hold: valid=%b out=%h, required valid=0 out=%h", bcd_valid, bcd_out, exp_bcd);
    end
  endtask

  task automatic test_back_to_back();
    int                  pulses = 0;
    int                  second_at = 0;
    logic [4*DIGITS-1:0] vals [2];
    vals[0] = '0;
    vals[1] = '0;
    @(negedge clk);
    accum = 32'd5;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        if (pulses < 2) vals[pulses] = bcd_out;
        pulses++;
        if (pulses == 2) second_at = i;
      end
      if (i == 10) accum = 32'd77;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("[TB] FAIL b2b_pulses: got %0d, required 2", pulses);
    end
    checks++;
    if (vals[0] !== model_bcd(32'd5)) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h, required %h", vals[0], model_bcd(32'd5));
    end
    checks++;
    if (vals[1] !== model_bcd(32'd77)) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h, required %h", vals[1], model_bcd(32'd77));
    end
    checks++;
    if (second_at != 2 * BITS + 3) begin
      errors++;
      $display("[TB] FAIL b2b_restart: second pulse at cycle %0d, required %0d", second_at, 2 * BITS + 3);
    end
  endtask

  task automatic test_reset_abort();
    int pulses   = 0;
    int first_at = 0;
    logic [4*DIGITS-1:0] got_val;
    got_val = '0;
    @(negedge clk);
    accum = 32'd999;
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_busy: got %b, required 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bcd_out !== '0 || busy !== 1'b0 || bcd_valid !== 1'b0 || sign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_clear: out=%h busy=%b valid=%b sign=%b, required all 0",
               bcd_out, busy, bcd_valid, sign);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        pulses++;
        if (first_at == 0) begin
          first_at = i;
          got_val  = bcd_out;
        end
      end
    end
    checks++;
    if (pulses != 1 || first_at != BITS + 1) begin
      errors++;
      $display("[TB] FAIL abort_restart: %0d pulses, first at %0d, required 1 pulse at %0d",
               pulses, first_at, BITS + 1);
    end
    checks++;
    if (got_val !== model_bcd(32'd999)) begin
      errors++;
      $display("[TB] FAIL abort_value: got %h, required %h", got_val, model_bcd(32'd999));
    end
  endtask

  task automatic test_extremes();
    logic [BITS-1:0] vals [5];
    int              cycles;
    bit              got;
    vals[0] = 32'hFFFF_FFFF;
    vals[1] = 32'h8000_0000;
    vals[2] = 32'h7FFF_FFFF;
    vals[3] = 32'h0000_0001;
    vals[4] = 32'h0000_0000;
    foreach (vals[i]) begin
      @(negedge clk);
      accum = vals[i];
      wait_valid(60, cycles, got);
      checks++;
      if (!got || cycles != BITS + 1) begin
        errors++;
        $display("[TB] FAIL extreme_latency %h: valid after %0d cycles (seen=%0d), required %0d",
                 vals[i], cycles, got, BITS + 1);
      end
      checks++;
      if (bcd_out !== model_bcd(vals[i]) || sign !== model_sign(vals[i])) begin
        errors++;
        $display("[TB] FAIL extreme_value %h: got %h sign=%b, required %h sign=%b",
                 vals[i], bcd_out, sign, model_bcd(vals[i]), model_sign(vals[i]));
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [BITS-1:0] v;
    int              cycles;
    bit              got;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      if (v == accum) v = ~v;
      @(negedge clk);
      accum = v;
      wait_valid(60, cycles, got);
      checks++;
      if (!got || cycles != BITS + 1) begin
        errors++;
        $display("[TB] FAIL random_latency %h: valid after %0d cycles (seen=%0d), required %0d",
                 v, cycles, got, BITS + 1);
      end
      checks++;
      if (bcd_out !== model_bcd(v) || sign !== model_sign(v)) begin
        errors++;
        $display("[TB] FAIL random_value %h: got %h sign=%b, required %h sign=%b",
                 v, bcd_out, sign, model_bcd(v), model_sign(v));
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    accum = '0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_reset_abort();
    test_extremes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
